// File: rtl/apu_len_pkg.sv
// Shared constants for the APU length counters: table widths, the 32-entry
// length table, and the per-edge action codes used by the counter datapath.
package apu_len_pkg;

  localparam int LEN_IDX_W = 5;
  localparam int LEN_CNT_W = 8;
  localparam int LEN_ENTRIES = 1 << LEN_IDX_W;

  // Index order follows the DB[7:3] encoding of the channel's 4th register.
  localparam logic [LEN_CNT_W-1:0] LEN_LUT [LEN_ENTRIES] = '{
    8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
  };

  typedef enum logic [2:0] {
    LEN_RESET,
    LEN_CLEAR,
    LEN_LOAD,
    LEN_DEC,
    LEN_HOLD
  } len_action_e;

  function automatic logic [LEN_CNT_W-1:0] len_lookup(input logic [LEN_IDX_W-1:0] idx);
    return LEN_LUT[idx];
  endfunction

endpackage

// File: rtl/length_lut.sv
// Combinational length-table ROM; one copy serves square, triangle and noise
// counters alike.
module length_lut
  import apu_len_pkg::*;
(
  input  logic [LEN_IDX_W-1:0] idx,
  output logic [LEN_CNT_W-1:0] val
);

  always_comb begin
    val = len_lookup(idx);
  end

endmodule

// File: rtl/length_counter.sv
// Per-channel APU length counter: loads from the length table on register-3
// writes, counts down on half-frame strobes, and silences the channel at zero.
module length_counter
  import apu_len_pkg::*;
#(
  parameter int ENABLE_BIT = 0
) (
  input  logic       ACLK,
  input  logic       RES,
  input  logic [7:0] DB,
  input  logic       WR3,
  input  logic       W4015,
  input  logic       nLFO2,
  input  logic       LC,
  output logic       NOSQ,
  output logic       LEN_ACT
);

  logic [LEN_CNT_W-1:0] cnt;
  logic [LEN_CNT_W-1:0] cnt_next;
  logic [LEN_CNT_W-1:0] lut_val;
  logic                 en;
  logic                 en_next;
  logic                 half;
  logic                 cnt_zero;
  len_action_e          action;

  // Only the enable bit and the length index are meaningful on DB.
  logic unused_db;
  assign unused_db = ^DB;

  length_lut u_lut (
    .idx (DB[7:3]),
    .val (lut_val)
  );

  assign half     = ~nLFO2;
  assign cnt_zero = (cnt == '0);
  assign NOSQ     = cnt_zero;
  assign LEN_ACT  = ~cnt_zero;

  // A half-frame on a live count wins over a simultaneous load, even when the
  // halt flag keeps that decrement from happening.
  always_comb begin
    action   = LEN_HOLD;
    cnt_next = cnt;
    en_next  = en;

    if (RES) begin
      action  = LEN_RESET;
      en_next = 1'b0;
    end else begin
      if (W4015) begin
        en_next = DB[ENABLE_BIT];
      end
      if (!en) begin
        action = LEN_CLEAR;
      end else if (WR3 && !(half && !cnt_zero)) begin
        action = LEN_LOAD;
      end else if (half && !LC && !cnt_zero) begin
        action = LEN_DEC;
      end
    end

    unique case (action)
      LEN_RESET: cnt_next = '0;
      LEN_CLEAR: cnt_next = '0;
      LEN_LOAD:  cnt_next = lut_val;
      LEN_DEC:   cnt_next = cnt - 8'd1;
      default:   cnt_next = cnt;
    endcase
  end

  always_ff @(posedge ACLK) begin
    cnt <= cnt_next;
    en  <= en_next;
  end

endmodule

// File: doc/length_counter.md
Name: length_counter

Overview:
Per-channel APU length counter. It receives the square channel's halt flag (SQ_LC) and drives the channel's NOSQ silence input.
- Loads an 8-bit count from a 32-entry table on the channel's 4th-register write ($4003/$4007).
- Decrements on half-frame strobes from the frame sequencer.
- Exposes a nonzero status bit for the $4015 read path.
- One instance per channel; the channel is selected by parameter.

Parameters:
ENABLE_BIT, 0, DB bit index (0..3) sampled on W4015 as this channel's enable.

Ports:
ACLK  input  1  APU clock; all state updates on rising edge
RES  input  1  synchronous active-high reset
DB  input  8  CPU data bus (write data)
WR3  input  1  one-cycle strobe: write to channel register 3; DB[7:3] = length index
W4015  input  1  one-cycle strobe: write to $4015 (channel enables)
nLFO2  input  1  active-low half-frame clock from frame sequencer
LC  input  1  halt flag from square channel (SQ_LC); 1 = hold count
NOSQ  output  1  1 when count == 0 (silences channel)
LEN_ACT  output  1  1 when count != 0 ($4015 status read bit)

Behaviour:
State:
- cnt[7:0] is the down counter.
- en is the enable flag.
- Both are registered on ACLK.

Outputs:
- NOSQ = (cnt == 0) and LEN_ACT = ~NOSQ, both combinational from cnt.
- No further latency: outputs change in the same cycle cnt updates.

Reset:
- RES=1 at a rising edge sets cnt=0, en=0, giving NOSQ=1 and LEN_ACT=0.
- RES dominates every other input in that cycle.
- RES asserted mid-count clears immediately at the next edge.

Enable:
- On W4015, en <= DB[ENABLE_BIT].
- Whenever en==0 (registered value), cnt <= 0 every cycle, overriding load and decrement.
- A W4015 clearing en takes effect on cnt one cycle later: cnt is zero two edges after the strobe.

Load:
- Condition: WR3 && en && !(half && cnt != 0).
- Action: cnt <= LUT[DB[7:3]].
- A WR3 while en==0 is discarded and not remembered.

Half-frame (half = ~nLFO2):
- Each cycle with half && en && !LC && cnt != 0: cnt <= cnt - 1.
- cnt == 0 never wraps; it stays 0.
- LC=1 freezes cnt; it does not block loads.
- nLFO2 low for N cycles gives N decrements. The sequencer guarantees 1-cycle pulses; the block does no edge detection.

Simultaneous WR3 and half (hardware quirk):
- If cnt != 0, the decrement (if not halted) wins and the load is ignored.
- If cnt == 0, the load wins.
- With LC=1 and cnt != 0 in the same cycle, the load is still ignored.

Simultaneous W4015 and WR3:
- The load uses the pre-write en.
- A disable then clears on the following cycle.

Priority per edge: RES > (en==0 clear) > quirk-gated load > decrement > hold.

LUT (index 0..31): 10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30.

Decomposition:
- Package apu_len_pkg:
  - LEN_LUT constant (32 x 8-bit)
  - LEN_IDX_W = 5
  - LEN_CNT_W = 8
- Sub-module length_lut: combinational ROM, input idx[4:0], output val[7:0]. It is shared by the square, triangle and noise instances.

Test Plan:
1. Reset: hold RES 2 cycles with WR3/W4015 active -> cnt=0, NOSQ=1, LEN_ACT=0.
2. Enable + load + countdown:
   - Stimulus: W4015 DB=0x01 (ENABLE_BIT=0); WR3 DB=0x08 (idx1).
   - Expect cnt=254 and NOSQ=0.
   - Then 254 one-cycle nLFO2 pulses -> NOSQ=1 after the 254th; a further pulse leaves cnt=0.
3. Halt: load idx 0 (10); LC=1 with 5 pulses -> cnt stays 10; LC=0 with 3 pulses -> cnt=7.
4. Disable/ignore:
   - W4015 DB=0x00 with cnt=7 -> cnt=0 two edges after the strobe.
   - WR3 DB=0xF8 while disabled -> cnt stays 0, NOSQ=1.
5. Quirk:
   - cnt=5, WR3 idx 4 (40) with nLFO2 low in the same cycle -> cnt=4.
   - cnt=0, same stimulus -> cnt=40.
6. Parameter: ENABLE_BIT=1 instance; W4015 DB=0x01 -> en=0, so WR3 is ignored; W4015 DB=0x02 -> loads succeed.
